pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-004 locker  input  1  from hazard detect unit; 1 = downstream IF_ID loads this cycle, 0 = IF_ID holds.
REQ-005 redirect  input  1  taken branch/jump from execute; one-cycle pulse.
REQ-006 redirectAddr  input  32  redirect target; bits [1:0] ignored and treated as 2'b00.
REQ-007 romReq  output  1  one-cycle ROM read request pulse.
REQ-008 romAddr  output  32  ROM read address; valid while romReq=1.
REQ-009 romValid  input  1  ROM response strobe; latency >=1 cycle after romReq; in order.
REQ-010 romData  input  32  instruction word; valid while romValid=1.
REQ-011 addrOut  output  32  PC of head instruction, to IF_ID addrIn.
REQ-012 dataOut  output  32  head instruction word, to IF_ID dataIn.
REQ-013 validOut  output  1  1 = addrOut/dataOut hold a real instruction.

Function
REQ-014 Internal state: pc register (next address to request), 2-entry FIFO of {addr, data}, FSM states IDLE, WAIT, DISCARD.
REQ-015 At most one ROM request outstanding at any time.
REQ-016 IDLE: issue romReq=1, romAddr=pc when (FIFO count) < 2 and redirect=0; pc <= pc+4; go WAIT. Otherwise stay IDLE, romReq=0.
REQ-017 pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 WAIT: on romValid=1 push {request address, romData} into FIFO, go IDLE; no new request issued in the same cycle.
REQ-019 Outputs driven from FIFO head: validOut=1 iff count>0; addrOut/dataOut = head entry, held stable while locker=0.
REQ-020 Pop head when validOut=1 and locker=1; push and pop in the same cycle are both performed, count unchanged.
REQ-021 Push never occurs when FIFO is full (guaranteed by REQ-016 issue rule).
REQ-022 redirect=1 has highest priority: FIFO cleared, pc <= {redirectAddr[31:2],2'b00}, no romReq that cycle, validOut=0 from next cycle.
REQ-023 redirect in WAIT with romValid=0: go DISCARD; redirect in WAIT with romValid=1: response dropped, go IDLE.
REQ-024 redirect in IDLE: stay IDLE; first request to the new pc issued the following cycle.
REQ-025 DISCARD: next romValid response dropped (no push), then go IDLE; redirect in DISCARD updates pc, stays DISCARD.
REQ-026 Redirect-to-request latency: redirect at cycle N -> romReq with target at N+1 if nothing outstanding, else cycle after discarded response.
REQ-027 addrOut/dataOut when validOut=0 are don't-care but hold last value (no X propagation).

Reset
REQ-028 reset=0: pc=RESET_PC, FIFO empty, state IDLE, romReq=0, romAddr=0, addrOut=0, dataOut=0, validOut=0.
REQ-029 reset asserted mid-request: outstanding response discarded; FSM restarts in IDLE after release; first romReq at first posedge after release with romAddr=RESET_PC.
REQ-030 A romValid arriving after reset release with no request issued since release is ignored.

Verification
REQ-031 Reset release, ROM latency 1, locker=1 -> romAddr sequence 0,4,8,...; validOut rises 2 cycles after first romReq; addrOut 0,4,8 with matching data.
REQ-032 locker=0 for 6 cycles, latency 1 -> FIFO fills to 2 (addr 0,4), romReq stops; addrOut=0 held stable; on locker=1 fetch resumes at 8, no loss or duplicate.
REQ-033 redirect to 32'h0000_0103 while request to 0x10 outstanding, latency 3 -> response for 0x10 dropped; next romAddr=0x100; validOut=0 until 0x100 arrives.
REQ-034 redirect in same cycle as romValid -> that word never appears on dataOut; FIFO empty next cycle.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> romAddr FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 reset pulsed low mid-WAIT, late romValid after release -> ignored; romAddr=RESET_PC first.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch front end: keeps the fetch PC, issues single-outstanding
// ROM reads and queues returned words in a 2-entry FIFO whose head feeds IF_ID.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        locker,
  input  logic        redirect,
  input  logic [31:0] redirectAddr,
  output logic        romReq,
  output logic [31:0] romAddr,
  input  logic        romValid,
  input  logic [31:0] romData,
  output logic [31:0] addrOut,
  output logic [31:0] dataOut,
  output logic        validOut
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0][31:0] fifo_addr_q, fifo_addr_d;
  logic [1:0][31:0] fifo_data_q, fifo_data_d;

  logic        issue;
  logic        push;
  logic        pop;
  logic [31:0] tgt;

  // Low two bits of a redirect target are forced to word alignment.
  assign tgt = redirectAddr & ~32'h3;

  // Request/response sequencing; redirect always wins and kills any push.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = tgt;
        end else if (cnt_q < 2'd2) begin
          // Only issue with a free slot so the response can always be pushed.
          issue      = 1'b1;
          req_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = tgt;
          // A response landing with the redirect is simply dropped.
          state_d = romValid ? IDLE : DISCARD;
        end else if (romValid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (redirect) pc_d = tgt;
        if (romValid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gating keeps the request strobe quiet while reset is held.
  assign romReq  = issue & reset;
  assign romAddr = romReq ? pc_q : 32'h0;

  assign validOut = |cnt_q;
  assign addrOut  = fifo_addr_q[0];
  assign dataOut  = fifo_data_q[0];
  assign pop      = validOut & locker;

  // Shift FIFO, head in slot 0; entries are never cleared so the head holds.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    cnt_d       = cnt_q;
    if (redirect) begin
      cnt_d = 2'd0;
    end else if (push && pop) begin
      if (cnt_q == 2'd2) begin
        fifo_addr_d[0] = fifo_addr_q[1];
        fifo_data_d[0] = fifo_data_q[1];
        fifo_addr_d[1] = req_addr_q;
        fifo_data_d[1] = romData;
      end else begin
        fifo_addr_d[0] = req_addr_q;
        fifo_data_d[0] = romData;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        fifo_addr_d[0] = req_addr_q;
        fifo_data_d[0] = romData;
      end else begin
        fifo_addr_d[1] = req_addr_q;
        fifo_data_d[1] = romData;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      if (cnt_q == 2'd2) begin
        fifo_addr_d[0] = fifo_addr_q[1];
        fifo_data_d[0] = fifo_data_q[1];
      end
      cnt_d = cnt_q - 2'd1;
    end
  end

  // State registers; reset drops any outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= 32'h0;
      cnt_q       <= 2'd0;
      fifo_addr_q <= '0;
      fifo_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      cnt_q       <= cnt_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

endmodule
